// File: rtl/synth_harness_pkg.sv
// Shared definitions for the synthesis input/output harness pair.
package synth_harness_pkg;

    localparam int DEFAULT_HARNESS_WIDTH = 354;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } harness_state_t;

    // Bit-index counter width; one spare bit keeps WIDTH=1 at a legal width.
    function automatic int harness_cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/synth_output_harness_if.sv
// Capture/serial bundle between the wide DUT output vector and the pin-side logic.
interface synth_output_harness_if
    import synth_harness_pkg::*;
#(
    parameter int WIDTH = DEFAULT_HARNESS_WIDTH
);
    logic [WIDTH-1:0] par_in;
    logic             load_en;
    logic             clr_overrun;
    logic             ser_out;
    logic             busy;
    logic             frame_done;
    logic             overrun;

    modport master (
        output par_in, load_en, clr_overrun,
        input  ser_out, busy, frame_done, overrun
    );

    modport slave (
        input  par_in, load_en, clr_overrun,
        output ser_out, busy, frame_done, overrun
    );
endinterface

// File: rtl/harness_piso_reg.sv
// Parallel-load, shift-right register with a serial tap and running parity.
module harness_piso_reg
    import synth_harness_pkg::*;
#(
    parameter int WIDTH = DEFAULT_HARNESS_WIDTH
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] par_in,
    output logic             ser_tap,
    output logic             next_tap,
    output logic             par_acc
);
    logic [WIDTH-1:0] shreg_q, shreg_d, shifted;
    logic             par_acc_q, par_acc_d;

    // Load wins over shift; the accumulator folds in the bit leaving position 0.
    always_comb begin
        shifted   = shreg_q >> 1;
        shreg_d   = shreg_q;
        par_acc_d = par_acc_q;
        if (load) begin
            shreg_d   = par_in;
            par_acc_d = 1'b0;
        end else if (shift) begin
            shreg_d   = shifted;
            par_acc_d = par_acc_q ^ shreg_q[0];
        end
    end

    // Register update with asynchronous clear.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            shreg_q   <= '0;
            par_acc_q <= 1'b0;
        end else begin
            shreg_q   <= shreg_d;
            par_acc_q <= par_acc_d;
        end
    end

    assign ser_tap  = shreg_q[0];
    // Bit that will sit in position 0 after the next shift (0 when WIDTH=1).
    assign next_tap = shifted[0];
    assign par_acc  = par_acc_q;
endmodule

// File: rtl/synth_output_harness.sv
// Serialises a wide DUT output vector onto one pin, LSB first, with a trailing
// even-parity bit so synthesis must keep every captured bit.
module synth_output_harness
    import synth_harness_pkg::*;
#(
    parameter int WIDTH = DEFAULT_HARNESS_WIDTH,
    parameter int CNT_W = harness_cnt_w(WIDTH)
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    synth_output_harness_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    harness_state_t   state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             ser_out_q, ser_out_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic             overrun_q, overrun_d;
    logic             piso_load, piso_shift;
    logic             ser_tap, next_tap, par_acc;

    harness_piso_reg #(.WIDTH(WIDTH)) u_piso (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .load     (piso_load),
        .shift    (piso_shift),
        .par_in   (bus.par_in),
        .ser_tap  (ser_tap),
        .next_tap (next_tap),
        .par_acc  (par_acc)
    );

    // Next-state and next-output decode; outputs are registered one cycle ahead
    // so each flop already holds the value for the state being entered.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        ser_out_d    = 1'b0;
        busy_d       = 1'b0;
        frame_done_d = 1'b0;
        piso_load    = 1'b0;
        piso_shift   = 1'b0;

        // Set beats clear when an ignored request coincides with clr_overrun.
        overrun_d = overrun_q;
        if (bus.clr_overrun) overrun_d = 1'b0;
        if (state_q == SHIFT && bus.load_en) overrun_d = 1'b1;

        case (state_q)
            IDLE, PARITY: begin
                if (bus.load_en) begin
                    piso_load = 1'b1;
                    idx_d     = '0;
                    state_d   = SHIFT;
                    ser_out_d = bus.par_in[0];
                    busy_d    = 1'b1;
                end else begin
                    state_d   = IDLE;
                end
            end
            SHIFT: begin
                piso_shift = 1'b1;
                busy_d     = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d      = PARITY;
                    ser_out_d    = par_acc ^ ser_tap;
                    frame_done_d = 1'b1;
                end else begin
                    idx_d     = idx_q + CNT_W'(1);
                    ser_out_d = next_tap;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output flops; reset aborts any frame in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            ser_out_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            ser_out_q    <= ser_out_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.ser_out    = ser_out_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_synth_output_harness.sv
// Scoreboard bench: expected serial bits are queued when a frame is loaded and
// popped by per-instance monitors on each falling edge while busy.
module tb_synth_output_harness;

    typedef struct packed {
        logic ser;
        logic done;
    } exp_t;

    logic clk;
    logic rst_n;

    int n_vec = 0;
    int n_err = 0;

    exp_t q8[$];
    exp_t q1[$];
    exp_t qw[$];
    exp_t e8, e1, ew;

    synth_output_harness_if #(.WIDTH(8))   if8 ();
    synth_output_harness_if #(.WIDTH(1))   if1 ();
    synth_output_harness_if #(.WIDTH(354)) ifw ();

    synth_output_harness #(.WIDTH(8))   u8 (.CLK(clk), .RST_N(rst_n), .bus(if8));
    synth_output_harness #(.WIDTH(1))   u1 (.CLK(clk), .RST_N(rst_n), .bus(if1));
    synth_output_harness #(.WIDTH(354)) uw (.CLK(clk), .RST_N(rst_n), .bus(ifw));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push_frame8(input logic [7:0] v);
        for (int i = 0; i < 8; i++) q8.push_back('{ser: v[i], done: 1'b0});
        q8.push_back('{ser: ^v, done: 1'b1});
    endtask

    task automatic push_frame1(input logic v);
        q1.push_back('{ser: v, done: 1'b0});
        q1.push_back('{ser: v, done: 1'b1});
    endtask

    task automatic push_framew(input logic [353:0] v);
        for (int i = 0; i < 354; i++) qw.push_back('{ser: v[i], done: 1'b0});
        qw.push_back('{ser: ^v, done: 1'b1});
    endtask

    // One isolated WIDTH=8 frame; par_in is changed to v_after once captured.
    task automatic run_frame8(input string tag, input logic [7:0] v, input logic [7:0] v_after);
        if8.par_in  = v;
        if8.load_en = 1'b1;
        push_frame8(v);
        @(negedge clk);
        if8.load_en = 1'b0;
        if8.par_in  = v_after;
        check_val({tag, "_busy_first"}, if8.busy, 1);
        repeat (9) @(negedge clk);
        check_val({tag, "_idle_after"}, if8.busy, 0);
        check_val({tag, "_q_drained"}, q8.size(), 0);
        check_val({tag, "_no_overrun"}, if8.overrun, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (if8.busy) begin
                check_val("w8_expected_bit", 32'(q8.size() != 0), 1);
                if (q8.size() != 0) begin
                    e8 = q8.pop_front();
                    check_val("w8_ser", if8.ser_out, e8.ser);
                    check_val("w8_done", if8.frame_done, e8.done);
                end
            end else begin
                check_val("w8_idle_ser", if8.ser_out, 0);
                check_val("w8_idle_done", if8.frame_done, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (if1.busy) begin
                check_val("w1_expected_bit", 32'(q1.size() != 0), 1);
                if (q1.size() != 0) begin
                    e1 = q1.pop_front();
                    check_val("w1_ser", if1.ser_out, e1.ser);
                    check_val("w1_done", if1.frame_done, e1.done);
                end
            end else begin
                check_val("w1_idle_done", if1.frame_done, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (ifw.busy) begin
                check_val("w354_expected_bit", 32'(qw.size() != 0), 1);
                if (qw.size() != 0) begin
                    ew = qw.pop_front();
                    check_val("w354_ser", ifw.ser_out, ew.ser);
                    check_val("w354_done", ifw.frame_done, ew.done);
                end
            end else begin
                check_val("w354_idle_done", ifw.frame_done, 0);
            end
        end
    end

    initial begin
        logic [353:0] vec;

        rst_n = 1'b1;
        if8.par_in = '0; if8.load_en = 1'b0; if8.clr_overrun = 1'b0;
        if1.par_in = '0; if1.load_en = 1'b0; if1.clr_overrun = 1'b0;
        ifw.par_in = '0; ifw.load_en = 1'b0; ifw.clr_overrun = 1'b0;
        #1 rst_n = 1'b0;

        repeat (3) @(negedge clk);
        check_val("rst_ser", if8.ser_out, 0);
        check_val("rst_busy", if8.busy, 0);
        check_val("rst_done", if8.frame_done, 0);
        check_val("rst_overrun", if8.overrun, 0);
        check_val("rst_w1_busy", if1.busy, 0);
        check_val("rst_w354_busy", ifw.busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_busy", if8.busy, 0);

        run_frame8("a5", 8'hA5, 8'hA5);
        run_frame8("odd07", 8'h07, 8'hF0);

        // Back-to-back: second load requested in the PARITY cycle.
        if8.par_in  = 8'hFF;
        if8.load_en = 1'b1;
        push_frame8(8'hFF);
        @(negedge clk);
        if8.load_en = 1'b0;
        if8.par_in  = 8'h00;
        repeat (8) @(negedge clk);
        check_val("b2b_parity_done", if8.frame_done, 1);
        if8.load_en = 1'b1;
        push_frame8(8'h00);
        @(negedge clk);
        if8.load_en = 1'b0;
        if8.par_in  = 8'h81;
        check_val("b2b_no_gap", if8.busy, 1);
        check_val("b2b_overrun", if8.overrun, 0);
        repeat (9) @(negedge clk);
        check_val("b2b_idle", if8.busy, 0);
        check_val("b2b_q_drained", q8.size(), 0);
        check_val("b2b_overrun_end", if8.overrun, 0);

        // Overrun from a load request in SHIFT; the frame must be unaffected.
        if8.par_in  = 8'h3C;
        if8.load_en = 1'b1;
        push_frame8(8'h3C);
        @(negedge clk);
        if8.load_en = 1'b0;
        if8.par_in  = 8'hE7;
        repeat (3) @(negedge clk);
        check_val("ovr_before", if8.overrun, 0);
        if8.load_en = 1'b1;
        @(negedge clk);
        if8.load_en = 1'b0;
        check_val("ovr_set", if8.overrun, 1);
        repeat (5) @(negedge clk);
        check_val("ovr_idle", if8.busy, 0);
        check_val("ovr_q_drained", q8.size(), 0);
        check_val("ovr_sticky", if8.overrun, 1);
        if8.clr_overrun = 1'b1;
        @(negedge clk);
        if8.clr_overrun = 1'b0;
        check_val("ovr_clr", if8.overrun, 0);

        // Ignored load and clear in the same cycle: set wins.
        if8.par_in  = 8'hC3;
        if8.load_en = 1'b1;
        push_frame8(8'hC3);
        @(negedge clk);
        if8.load_en = 1'b0;
        @(negedge clk);
        if8.load_en     = 1'b1;
        if8.clr_overrun = 1'b1;
        @(negedge clk);
        if8.load_en     = 1'b0;
        if8.clr_overrun = 1'b0;
        check_val("ovr_set_wins", if8.overrun, 1);
        repeat (7) @(negedge clk);
        check_val("ovr2_idle", if8.busy, 0);
        check_val("ovr2_q_drained", q8.size(), 0);
        if8.clr_overrun = 1'b1;
        @(negedge clk);
        if8.clr_overrun = 1'b0;
        check_val("ovr2_clr", if8.overrun, 0);

        // WIDTH=1 frames.
        for (int k = 0; k < 2; k++) begin
            if1.par_in  = (k == 0) ? 1'b1 : 1'b0;
            if1.load_en = 1'b1;
            push_frame1(if1.par_in[0]);
            @(negedge clk);
            if1.load_en = 1'b0;
            check_val("w1_busy_first", if1.busy, 1);
            @(negedge clk);
            check_val("w1_parity_done", if1.frame_done, 1);
            @(negedge clk);
            check_val("w1_idle", if1.busy, 0);
            check_val("w1_q_drained", q1.size(), 0);
        end

        // WIDTH=354 random vector.
        for (int i = 0; i < 354; i++) vec[i] = 1'($urandom_range(0, 1));
        ifw.par_in  = vec;
        ifw.load_en = 1'b1;
        push_framew(vec);
        @(negedge clk);
        ifw.load_en = 1'b0;
        ifw.par_in  = ~vec;
        check_val("w354_busy_first", ifw.busy, 1);
        repeat (355) @(negedge clk);
        check_val("w354_idle", ifw.busy, 0);
        check_val("w354_q_drained", qw.size(), 0);

        // Asynchronous reset in the middle of a frame (with overrun set).
        if8.par_in  = 8'hFF;
        if8.load_en = 1'b1;
        push_frame8(8'hFF);
        @(negedge clk);
        if8.load_en = 1'b0;
        @(negedge clk);
        if8.load_en = 1'b1;
        @(negedge clk);
        if8.load_en = 1'b0;
        check_val("mid_ovr_set", if8.overrun, 1);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst_ser", if8.ser_out, 0);
        check_val("async_rst_busy", if8.busy, 0);
        check_val("async_rst_done", if8.frame_done, 0);
        check_val("async_rst_overrun", if8.overrun, 0);
        q8.delete();
        @(negedge clk);
        check_val("rst_hold_busy", if8.busy, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_val("abort_no_busy", if8.busy, 0);
        run_frame8("after_rst", 8'h5A, 8'h00);

        check_val("final_q8", q8.size(), 0);
        check_val("final_q1", q1.size(), 0);
        check_val("final_qw", qw.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
